riscv_irq_arbiter: RTL and testbench

Upstream source for the core interrupt controller. It captures NUM_IRQ external interrupt lines as edge-latched or level-sampled pending bits. It holds a per-line configuration table (enable, level, secure) and arbitrates the highest-level pending line each cycle. The result is presented as registered irq_pending_o / irq_id_o / irq_lev_o / irq_sec_o, which drive the controller's irq_pending_i / irq_id_i / irq_lev_i / irq_sec_i. The controller's acknowledge clears the served pending bit.

---
 rtl/riscv_irq_arbiter.sv | 122 ++++++++++++
 tb/tb_riscv_irq_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_irq_arbiter.sv
// Interrupt source arbiter: latches edge/level interrupt lines into pending bits and presents
// the highest-level enabled pending line to the core interrupt controller through registers.
module riscv_irq_arbiter #(
    parameter int unsigned NUM_IRQ     = 32,
    parameter logic [63:0] EDGE_MASK   = 64'h0,
    parameter bit          PULP_SECURE = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               cfg_we_i,
    input  logic [9:0]         cfg_idx_i,
    input  logic               cfg_en_i,
    input  logic [7:0]         cfg_lev_i,
    input  logic               cfg_sec_i,
    input  logic               irq_ack_i,
    input  logic [9:0]         irq_ack_id_i,
    output logic               irq_pending_o,
    output logic [9:0]         irq_id_o,
    output logic [7:0]         irq_lev_o,
    output logic               irq_sec_o
);

    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] r_irq_d;
    logic [NUM_IRQ-1:0] r_en;
    logic [NUM_IRQ-1:0] r_sec;
    logic [7:0]         r_lev [NUM_IRQ];

    logic               r_out_pending;
    logic [9:0]         r_out_id;
    logic [7:0]         r_out_lev;
    logic               r_out_sec;

    logic [NUM_IRQ-1:0] w_pending_d;
    logic               w_win_valid;
    logic [9:0]         w_win_id;
    logic [7:0]         w_win_lev;
    logic               w_win_sec;

    // Edge lines: a fresh rising edge beats a same-cycle ack; level lines just track the input.
    always_comb begin
        w_pending_d = '0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (EDGE_MASK[i]) begin
                w_pending_d[i] = (irq_i[i] & ~r_irq_d[i]) |
                                 (r_pending[i] & ~(irq_ack_i && (irq_ack_id_i == 10'(i))));
            end else begin
                w_pending_d[i] = irq_i[i];
            end
        end
    end

    // Strict '>' scanning upward keeps the lowest index on ties and rejects level 0.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_id    = '0;
        w_win_lev   = '0;
        w_win_sec   = 1'b0;
        for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (r_pending[i] && r_en[i] && (r_lev[i] > w_win_lev)) begin
                w_win_valid = 1'b1;
                w_win_id    = 10'(i);
                w_win_lev   = r_lev[i];
                w_win_sec   = r_sec[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_irq_d   <= '0;
        end else begin
            r_pending <= w_pending_d;
            r_irq_d   <= irq_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_en  <= '0;
            r_sec <= '0;
            for (int i = 0; i < int'(NUM_IRQ); i++) begin
                r_lev[i] <= '0;
            end
        end else if (cfg_we_i) begin
            for (int i = 0; i < int'(NUM_IRQ); i++) begin
                if (cfg_idx_i == 10'(i)) begin
                    r_en[i]  <= cfg_en_i;
                    r_lev[i] <= cfg_lev_i;
                    r_sec[i] <= cfg_sec_i;
                end
            end
        end
    end

    // An ack forces a one-cycle bubble so an already-served id is never presented twice.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_pending <= 1'b0;
            r_out_id      <= '0;
            r_out_lev     <= '0;
            r_out_sec     <= 1'b0;
        end else if (irq_ack_i) begin
            r_out_pending <= 1'b0;
        end else if (w_win_valid) begin
            r_out_pending <= 1'b1;
            r_out_id      <= w_win_id;
            r_out_lev     <= w_win_lev;
            r_out_sec     <= PULP_SECURE ? w_win_sec : 1'b1;
        end else begin
            r_out_pending <= 1'b0;
        end
    end

    assign irq_pending_o = r_out_pending;
    assign irq_id_o      = r_out_id;
    assign irq_lev_o     = r_out_lev;
    assign irq_sec_o     = r_out_sec;

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// Scoreboard bench for riscv_irq_arbiter: one instance without and one with per-line secure bits,
// both driven identically; expected outputs are queued per cycle and checked at the falling edge.
module tb_riscv_irq_arbiter;

    localparam int unsigned NIRQ = 32;

    logic            clk;
    logic            rst_n;
    logic [NIRQ-1:0] irq;
    logic            cfg_we;
    logic [9:0]      cfg_idx;
    logic            cfg_en;
    logic [7:0]      cfg_lev;
    logic            cfg_sec;
    logic            ack;
    logic [9:0]      ack_id;

    logic            pend,   pend_s;
    logic [9:0]      id,     id_s;
    logic [7:0]      lev,    lev_s;
    logic            sec,    sec_s;

    riscv_irq_arbiter #(
        .NUM_IRQ    (NIRQ),
        .EDGE_MASK  (64'h80),
        .PULP_SECURE(1'b0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_i        (irq),
        .cfg_we_i     (cfg_we),
        .cfg_idx_i    (cfg_idx),
        .cfg_en_i     (cfg_en),
        .cfg_lev_i    (cfg_lev),
        .cfg_sec_i    (cfg_sec),
        .irq_ack_i    (ack),
        .irq_ack_id_i (ack_id),
        .irq_pending_o(pend),
        .irq_id_o     (id),
        .irq_lev_o    (lev),
        .irq_sec_o    (sec)
    );

    riscv_irq_arbiter #(
        .NUM_IRQ    (NIRQ),
        .EDGE_MASK  (64'h80),
        .PULP_SECURE(1'b1)
    ) dut_s (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_i        (irq),
        .cfg_we_i     (cfg_we),
        .cfg_idx_i    (cfg_idx),
        .cfg_en_i     (cfg_en),
        .cfg_lev_i    (cfg_lev),
        .cfg_sec_i    (cfg_sec),
        .irq_ack_i    (ack),
        .irq_ack_id_i (ack_id),
        .irq_pending_o(pend_s),
        .irq_id_o     (id_s),
        .irq_lev_o    (lev_s),
        .irq_sec_o    (sec_s)
    );

    typedef struct {
        int         cyc;
        string      tag;
        logic       pend;
        logic [9:0] id;
        logic [7:0] lev;
        logic       sec;
        logic       sec_s;
    } exp_t;

    exp_t sb_q[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_out(input int dly, input string tag, input logic p, input logic [9:0] i,
                              input logic [7:0] l, input logic s, input logic ss);
        exp_t e;
        e.cyc   = cyc + dly;
        e.tag   = tag;
        e.pend  = p;
        e.id    = i;
        e.lev   = l;
        e.sec   = s;
        e.sec_s = ss;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        for (int k = sb_q.size() - 1; k >= 0; k--) begin
            if (sb_q[k].cyc == cyc) begin
                e = sb_q[k];
                check_val({e.tag, ".pend"},  32'(pend),   32'(e.pend));
                check_val({e.tag, ".id"},    32'(id),     32'(e.id));
                check_val({e.tag, ".lev"},   32'(lev),    32'(e.lev));
                check_val({e.tag, ".sec"},   32'(sec),    32'(e.sec));
                check_val({e.tag, ".sec_s"}, 32'(sec_s),  32'(e.sec_s));
                check_val({e.tag, ".pend_s"}, 32'(pend_s), 32'(e.pend));
                sb_q.delete(k);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [9:0] idx, input logic en, input logic [7:0] l,
                             input logic s);
        cfg_we  = 1'b1;
        cfg_idx = idx;
        cfg_en  = en;
        cfg_lev = l;
        cfg_sec = s;
        wait_cyc(1);
        cfg_we  = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        irq     = '1;
        cfg_we  = 1'b0;
        cfg_idx = '0;
        cfg_en  = 1'b0;
        cfg_lev = '0;
        cfg_sec = 1'b0;
        ack     = 1'b0;
        ack_id  = '0;

        // Reset held with every line asserted
        wait_cyc(1);
        expect_out(0, "rst0", 1'b0, 10'd0, 8'h00, 1'b0, 1'b0);
        expect_out(1, "rst1", 1'b0, 10'd0, 8'h00, 1'b0, 1'b0);
        expect_out(2, "rst2", 1'b0, 10'd0, 8'h00, 1'b0, 1'b0);
        wait_cyc(2);
        irq = '0;
        wait_cyc(1);
        rst_n = 1'b1;

        // Level arbitration: 3 and 9 tie at 0x20, lowest index wins
        cfg_write(10'd5, 1'b1, 8'h10, 1'b0);
        cfg_write(10'd9, 1'b1, 8'h20, 1'b0);
        cfg_write(10'd3, 1'b1, 8'h20, 1'b0);
        irq[3] = 1'b1;
        irq[5] = 1'b1;
        irq[9] = 1'b1;
        expect_out(1, "lvl_lat", 1'b0, 10'd0, 8'h00, 1'b0, 1'b0);
        expect_out(2, "lvl_win", 1'b1, 10'd3, 8'h20, 1'b1, 1'b0);
        wait_cyc(2);
        ack    = 1'b1;
        ack_id = 10'd3;
        wait_cyc(1);
        ack    = 1'b0;
        expect_out(0, "lvl_ack_bub", 1'b0, 10'd3, 8'h20, 1'b1, 1'b0);
        expect_out(1, "lvl_ack_re",  1'b1, 10'd3, 8'h20, 1'b1, 1'b0);
        wait_cyc(1);
        irq[3] = 1'b0;
        expect_out(2, "lvl_next", 1'b1, 10'd9, 8'h20, 1'b1, 1'b0);
        wait_cyc(2);
        irq = '0;
        expect_out(2, "lvl_idle", 1'b0, 10'd9, 8'h20, 1'b1, 1'b0);
        wait_cyc(2);

        // Edge capture on line 7 and ack
        cfg_write(10'd7, 1'b1, 8'h04, 1'b1);
        irq[7] = 1'b1;
        wait_cyc(1);
        irq[7] = 1'b0;
        expect_out(1, "edge_cap",  1'b1, 10'd7, 8'h04, 1'b1, 1'b1);
        expect_out(3, "edge_hold", 1'b1, 10'd7, 8'h04, 1'b1, 1'b1);
        wait_cyc(3);
        ack    = 1'b1;
        ack_id = 10'd7;
        wait_cyc(1);
        ack    = 1'b0;
        expect_out(0, "edge_ack",  1'b0, 10'd7, 8'h04, 1'b1, 1'b1);
        expect_out(2, "edge_clr",  1'b0, 10'd7, 8'h04, 1'b1, 1'b1);
        wait_cyc(2);

        // New edge coincident with its ack: set wins, one bubble
        irq[7] = 1'b1;
        wait_cyc(1);
        irq[7] = 1'b0;
        wait_cyc(1);
        expect_out(0, "sim_pre", 1'b1, 10'd7, 8'h04, 1'b1, 1'b1);
        irq[7] = 1'b1;
        ack    = 1'b1;
        ack_id = 10'd7;
        wait_cyc(1);
        irq[7] = 1'b0;
        ack    = 1'b0;
        expect_out(0, "sim_bub",  1'b0, 10'd7, 8'h04, 1'b1, 1'b1);
        expect_out(1, "sim_set",  1'b1, 10'd7, 8'h04, 1'b1, 1'b1);
        expect_out(2, "sim_hold", 1'b1, 10'd7, 8'h04, 1'b1, 1'b1);
        wait_cyc(2);
        ack    = 1'b1;
        ack_id = 10'd7;
        wait_cyc(1);
        ack    = 1'b0;
        expect_out(1, "sim_clr", 1'b0, 10'd7, 8'h04, 1'b1, 1'b1);
        wait_cyc(1);

        // Disabled level line, then enabled
        cfg_write(10'd2, 1'b0, 8'h30, 1'b0);
        irq[2] = 1'b1;
        expect_out(2, "dis_none", 1'b0, 10'd7, 8'h04, 1'b1, 1'b1);
        wait_cyc(2);
        cfg_write(10'd2, 1'b1, 8'h30, 1'b0);
        expect_out(0, "en_lat", 1'b0, 10'd7, 8'h04, 1'b1, 1'b1);
        expect_out(1, "en_win", 1'b1, 10'd2, 8'h30, 1'b1, 1'b0);
        wait_cyc(1);

        // Out-of-range config writes and ack id are ignored
        cfg_write(10'h3FF, 1'b0, 8'h00, 1'b1);
        cfg_write(10'h022, 1'b0, 8'h00, 1'b1);
        expect_out(0, "oor_cfg0", 1'b1, 10'd2, 8'h30, 1'b1, 1'b0);
        expect_out(1, "oor_cfg1", 1'b1, 10'd2, 8'h30, 1'b1, 1'b0);
        wait_cyc(1);
        ack    = 1'b1;
        ack_id = 10'h3FF;
        wait_cyc(1);
        ack    = 1'b0;
        expect_out(0, "oor_ack_bub", 1'b0, 10'd2, 8'h30, 1'b1, 1'b0);
        expect_out(1, "oor_ack_re",  1'b1, 10'd2, 8'h30, 1'b1, 1'b0);
        wait_cyc(2);

        // Reset mid-operation drops a latched edge capture
        irq = '0;
        wait_cyc(2);
        irq[7] = 1'b1;
        wait_cyc(1);
        irq[7] = 1'b0;
        rst_n  = 1'b0;
        wait_cyc(1);
        rst_n  = 1'b1;
        expect_out(0, "mid_rst", 1'b0, 10'd0, 8'h00, 1'b0, 1'b0);
        cfg_write(10'd7, 1'b1, 8'h04, 1'b1);
        expect_out(0, "mid_drop0", 1'b0, 10'd0, 8'h00, 1'b0, 1'b0);
        expect_out(1, "mid_drop1", 1'b0, 10'd0, 8'h00, 1'b0, 1'b0);
        expect_out(2, "mid_drop2", 1'b0, 10'd0, 8'h00, 1'b0, 1'b0);
        wait_cyc(5);

        check_val("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
